// File: rtl/arm_cortex_m0_shift_execute.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : arm_cortex_m0_shift_execute                                |
// | Description : Thumb shift execute stage (LSL/LSR/ASR/ROR by register)    |
// |               with ARM amount semantics, N/Z/C generation, a one-entry   |
// |               valid/ready output register and the APSR N/Z/C flags.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module arm_cortex_m0_shift_execute #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_flags,
  input  logic             flag_we,
  input  logic [2:0]       flag_wdata,
  output logic [2:0]       apsr_nzc
);

  localparam logic [3:0]       c_OP_LSL = 4'b1010;
  localparam logic [3:0]       c_OP_LSR = 4'b1011;
  localparam logic [3:0]       c_OP_ASR = 4'b1100;
  localparam logic [3:0]       c_OP_ROR = 4'b1101;
  localparam logic [AMT_W-1:0] c_AMT_W  = AMT_W'(WIDTH);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [2:0]       r_out_flags;
  logic [2:0]       r_apsr;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_cin;
  logic [4:0]       w_sh;
  logic             w_n_zero;
  logic             w_n_small;
  logic             w_n_full;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic [2:0]       w_flags;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_cin      = r_apsr[0];

  // Amount classification: zero, 1..31 (handled by the 5-bit shifter), exactly 32, or beyond
  assign w_sh      = in_amount[4:0];
  assign w_n_zero  = (in_amount == '0);
  assign w_n_small = !w_n_zero && (in_amount < c_AMT_W);
  assign w_n_full  = (in_amount == c_AMT_W);

  // Shift datapath: result and carry-out for the presented op
  always_comb begin
    w_res = in_data;
    w_c   = w_cin;
    unique case (in_opcode)
      c_OP_LSL: begin
        if (w_n_small) begin
          w_res = in_data << w_sh;
          // last bit shifted out is Rm[32-n]; 5-bit negate gives that index for n=1..31
          w_c   = in_data[5'(5'd0 - w_sh)];
        end else if (w_n_full) begin
          w_res = '0;
          w_c   = in_data[0];
        end else if (!w_n_zero) begin
          w_res = '0;
          w_c   = 1'b0;
        end
      end
      c_OP_LSR: begin
        if (w_n_small) begin
          w_res = in_data >> w_sh;
          w_c   = in_data[5'(w_sh - 5'd1)];
        end else if (w_n_full) begin
          w_res = '0;
          w_c   = in_data[WIDTH-1];
        end else if (!w_n_zero) begin
          w_res = '0;
          w_c   = 1'b0;
        end
      end
      c_OP_ASR: begin
        if (w_n_small) begin
          w_res = $unsigned($signed(in_data) >>> w_sh);
          w_c   = in_data[5'(w_sh - 5'd1)];
        end else if (!w_n_zero) begin
          w_res = {WIDTH{in_data[WIDTH-1]}};
          w_c   = in_data[WIDTH-1];
        end
      end
      c_OP_ROR: begin
        // rotate by n mod 32; a zero rotate falls out naturally as Rm
        if (!w_n_zero) begin
          w_res = (in_data >> w_sh) | (in_data << 5'(5'd0 - w_sh));
          w_c   = w_res[WIDTH-1];
        end
      end
      default: begin
        w_res = in_data;
        w_c   = w_cin;
      end
    endcase
    w_flags = {w_res[WIDTH-1], (w_res == '0), w_c};
  end

  // One-entry output register: capture on accept, drop valid when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
    end else if (w_in_fire) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_res;
      r_out_flags  <= w_flags;
    end else if (w_out_fire) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Architectural N/Z/C: a flag-setting op wins over an external load in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_apsr <= '0;
    end else if (w_in_fire && in_set_flags) begin
      r_apsr <= w_flags;
    end else if (flag_we) begin
      r_apsr <= flag_wdata;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;
  assign apsr_nzc   = r_apsr;

endmodule
`default_nettype wire
